// File: rtl/acc_disp_pkg.sv
// Shared types and constants for the accumulator result display.
// Optional build macro: ACC_DISP_LEADING_ZERO_BLANK_EN.
package acc_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_W      = 12;
    localparam int BIN_W      = 8;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment order is {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] code;
        code = SEG_BLANK;
        if (d < 4'd10) begin
            code = SEG_TABLE[d];
        end
        return code;
    endfunction

endpackage

// File: rtl/acc_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter, one bit per clock.
// Optional build macro: ACC_DISP_LEADING_ZERO_BLANK_EN (not used here).
module acc_bin2bcd_seq
    import acc_disp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [BIN_W-1:0] i_bin,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);

    logic [BCD_W-1:0] r_bcd;
    logic [BIN_W-1:0] r_bin;
    logic [2:0]       r_cnt;
    logic             r_busy;
    logic [BCD_W-1:0] w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcd  <= '0;
            r_bin  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_bcd  <= '0;
            r_bin  <= i_bin;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
                r_busy <= 1'b0;
            end
        end
    end

    // High during the cycle whose edge performs the eighth shift
    assign o_done = r_busy && (r_cnt == 3'd7);
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/acc_result_display.sv
// Captures result ports A/B, converts to BCD and scans six 7-seg digits.
// Optional build macro: ACC_DISP_LEADING_ZERO_BLANK_EN (leading-zero blanking).
module acc_result_display
    import acc_disp_pkg::*;
#(
    parameter int SCAN_DIV = 4
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_A,
    input  logic [7:0] port_B,
    output logic [6:0] seg,
    output logic [5:0] dig_en,
    output logic       busy,
    output logic       upd_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    state_t           r_state;
    logic [7:0]       r_a_last;
    logic [7:0]       r_b_last;
    logic             r_sel_b;
    logic [3:0]       r_dig [NUM_DIGITS];
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_idx;
    logic [6:0]       r_seg;
    logic [5:0]       r_dig_en;

    logic             w_a_chg;
    logic             w_b_chg;
    logic             w_start;
    logic             w_done;
    logic [7:0]       w_bin;
    logic [BCD_W-1:0] w_bcd;
    logic [3:0]       w_cur;
    logic [6:0]       w_seg;

    // Compare against last captured values so no change is ever dropped
    assign w_a_chg = (port_A != r_a_last);
    assign w_b_chg = (port_B != r_b_last);
    assign w_start = (r_state == ST_IDLE) && (w_a_chg || w_b_chg);
    assign w_bin   = w_a_chg ? port_A : port_B;

    acc_bin2bcd_seq u_b2b (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_bin   (w_bin),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_a_last <= '0;
            r_b_last <= '0;
            r_sel_b  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_dig[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_a_chg) begin
                        r_a_last <= port_A;
                        r_sel_b  <= 1'b0;
                        r_state  <= ST_CONV;
                    end else if (w_b_chg) begin
                        r_b_last <= port_B;
                        r_sel_b  <= 1'b1;
                        r_state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (w_done) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (r_sel_b) begin
                        r_dig[3] <= w_bcd[11:8];
                        r_dig[4] <= w_bcd[7:4];
                        r_dig[5] <= w_bcd[3:0];
                    end else begin
                        r_dig[0] <= w_bcd[11:8];
                        r_dig[1] <= w_bcd[7:4];
                        r_dig[2] <= w_bcd[3:0];
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
            r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

`ifdef ACC_DISP_LEADING_ZERO_BLANK_EN
    logic [2:0] w_base;
    logic [2:0] w_pos;
    logic [3:0] w_hund;
`endif

    always_comb begin
        w_cur = r_dig[r_idx];
        w_seg = seg_encode(w_cur);
`ifdef ACC_DISP_LEADING_ZERO_BLANK_EN
        w_base = (r_idx >= 3'd3) ? 3'd3 : 3'd0;
        w_pos  = r_idx - w_base;
        w_hund = r_dig[w_base];
        if (w_pos == 3'd0 && w_cur == 4'd0) begin
            w_seg = SEG_BLANK;
        end
        if (w_pos == 3'd1 && w_hund == 4'd0 && w_cur == 4'd0) begin
            w_seg = SEG_BLANK;
        end
`endif
    end

    // Enable and segments share one register stage so they always match
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg    <= 7'h3F;
            r_dig_en <= 6'b000001;
        end else begin
            r_seg    <= w_seg;
            r_dig_en <= 6'b000001 << r_idx;
        end
    end

    assign seg      = r_seg;
    assign dig_en   = r_dig_en;
    assign busy     = (r_state != ST_IDLE);
    assign upd_done = (r_state == ST_WRITE);

endmodule

// File: tb/tb_acc_result_display.sv
// Directed + randomized bench for acc_result_display with a value-level model.
// Optional build macro: ACC_DISP_LEADING_ZERO_BLANK_EN.
module tb_acc_result_display;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] port_A = '0;
    logic [7:0] port_B = '0;
    logic [6:0] seg;
    logic [5:0] dig_en;
    logic       busy;
    logic       upd_done;

    int total = 0;
    int bad = 0;
    int e;
    int bc;
    int n;
    int act;
    logic [7:0] mA = '0;
    logic [7:0] mB = '0;
    logic [7:0] nA;
    logic [7:0] nB;

    acc_result_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .port_A   (port_A),
        .port_B   (port_B),
        .seg      (seg),
        .dig_en   (dig_en),
        .busy     (busy),
        .upd_done (upd_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int pos);
        int v, k, h, t, o, d;
        logic [6:0] s;
        v = (pos < 3) ? int'(mA) : int'(mB);
        k = pos % 3;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        d = (k == 0) ? h : (k == 1) ? t : o;
        s = seg_of(d);
`ifdef ACC_DISP_LEADING_ZERO_BLANK_EN
        if (k == 0 && h == 0) s = 7'h00;
        if (k == 1 && h == 0 && t == 0) s = 7'h00;
`endif
        return s;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_until_upd(input int chg_at, input logic [7:0] chg_val,
                                 output int edges, output int busy_cnt);
        edges = 0;
        busy_cnt = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            if (busy) busy_cnt++;
            if (edges == chg_at) port_A = chg_val;
        end while (!upd_done && edges < 200);
    endtask

    task automatic check_display(input string tag);
        logic [6:0] got [6];
        logic [5:0] seen;
        int pulses;
        int not_hot;
        seen = '0;
        pulses = 0;
        not_hot = 0;
        for (int i = 0; i < 6; i++) got[i] = 7'h7F;
        repeat (2 * 6 * SCAN_DIV + 2) begin
            @(negedge clk);
            if (upd_done) pulses++;
            if ($countones(dig_en) != 1) not_hot++;
            for (int i = 0; i < 6; i++) begin
                if (dig_en == (6'b000001 << i)) begin
                    got[i] = seg;
                    seen[i] = 1'b1;
                end
            end
        end
        chk({tag, "_seen"}, int'(seen), 63);
        chk({tag, "_onehot"}, not_hot, 0);
        chk({tag, "_extra_upd"}, pulses, 0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_seg%0d", tag, i), int'(got[i]), int'(exp_seg(i)));
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_dig_en", int'(dig_en), 1);
        chk("rst_seg", int'(seg), 'h3F);
        chk("rst_busy", int'(busy), 0);
        chk("rst_upd", int'(upd_done), 0);
        reset = 1'b0;
        act = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy || upd_done) act++;
        end
        chk("idle_activity", act, 0);
        check_display("rst_disp");

        // single A conversion 0 -> 55
        port_A = 8'd55;
        run_until_upd(0, 8'd0, e, bc);
        chk("a55_write_edge", e + 1, 10);
        chk("a55_busy_cycles", bc, 9);
        @(negedge clk);
        chk("a55_busy_after", int'(busy), 0);
        chk("a55_upd_after", int'(upd_done), 0);
        mA = 8'd55;
        check_display("a55");

        // scan cadence and order
        begin
            int guard;
            int run;
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (dig_en != 6'b100000 && guard < 100);
            do begin
                @(negedge clk);
                guard++;
            end while (dig_en != 6'b000001 && guard < 100);
            chk("scan_sync", int'(guard < 100), 1);
            for (int i = 0; i < 6; i++) begin
                run = 0;
                while (dig_en == (6'b000001 << i) && run < 50) begin
                    run++;
                    @(negedge clk);
                end
                chk($sformatf("scan_len%0d", i), run, SCAN_DIV);
            end
            chk("scan_wrap", int'(dig_en), 1);
        end

        // A and B change together: A first, B ten edges later
        port_A = 8'd100;
        run_until_upd(0, 8'd0, e, bc);
        chk("a100_lat", e, 9);
        @(negedge clk);
        port_A = 8'd55;
        port_B = 8'd210;
        run_until_upd(0, 8'd0, e, bc);
        chk("ab_first_lat", e, 9);
        run_until_upd(0, 8'd0, e, bc);
        chk("ab_second_lat", e, 10);
        mA = 8'd55;
        mB = 8'd210;
        check_display("ab");

        // A moves mid-conversion, picked up afterwards
        port_A = 8'd33;
        run_until_upd(0, 8'd0, e, bc);
        chk("a33_lat", e, 9);
        @(negedge clk);
        port_A = 8'd55;
        run_until_upd(4, 8'd77, e, bc);
        chk("mid_first_lat", e, 9);
        run_until_upd(0, 8'd0, e, bc);
        chk("mid_second_lat", e, 10);
        mA = 8'd77;
        check_display("mid");

        // reset during conversion
        port_A = 8'd200;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_upd", int'(upd_done), 0);
        chk("mrst_dig_en", int'(dig_en), 1);
        chk("mrst_seg", int'(seg), 'h3F);
        @(negedge clk);
        reset = 1'b0;
        run_until_upd(0, 8'd0, e, bc);
        chk("rec_a_lat", e, 9);
        run_until_upd(0, 8'd0, e, bc);
        chk("rec_b_lat", e, 10);
        mA = 8'd200;
        mB = 8'd210;
        check_display("rec");

        // small value, leading zero case
        port_A = 8'd5;
        run_until_upd(0, 8'd0, e, bc);
        chk("a5_lat", e, 9);
        mA = 8'd5;
        check_display("a5");

        // randomized values against the model
        for (int r = 0; r < 8; r++) begin
            nA = 8'($urandom_range(255, 0));
            nB = 8'($urandom_range(255, 0));
            if ($urandom_range(3, 0) == 0) nA = mA;
            if ($urandom_range(3, 0) == 0) nB = mB;
            n = int'(nA != mA) + int'(nB != mB);
            port_A = nA;
            port_B = nB;
            mA = nA;
            mB = nB;
            for (int k = 0; k < n; k++) begin
                run_until_upd(0, 8'd0, e, bc);
                chk($sformatf("rnd%0d_lat%0d", r, k), e, (k == 0) ? 9 : 10);
            end
            check_display($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
